// File: rtl/fir_pkg.sv
// Shared definitions for the FIR error monitor: sample widths, FSM state
// encoding and a saturating-add helper used by the result accumulators.
package fir_pkg;

   localparam int SAMPLE_W = 16;
   localparam int SQ_ACC_W = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fir_err_state_t;

   // Adds inc to acc and clamps the result at the all-ones value of a
   // 'width'-bit accumulator. Valid for width up to 63 with inc below 2^32.
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int unsigned width);
      logic [63:0] max_v;
      logic [63:0] sum;
      max_v = (64'd1 << width) - 64'd1;
      sum   = acc + inc;
      return (sum > max_v) ? max_v : sum;
   endfunction

endpackage

// File: rtl/abs_diff16.sv
// Unsigned 16-bit absolute difference with a nonzero flag. Purely
// combinational; the subtraction is ordered so it can never wrap.
module abs_diff16
   import fir_pkg::*;
(
   input  logic [SAMPLE_W-1:0] a,
   input  logic [SAMPLE_W-1:0] b,
   output logic [SAMPLE_W-1:0] mag,
   output logic                nonzero
);

   assign mag     = (a >= b) ? (a - b) : (b - a);
   assign nonzero = (a != b);

endmodule

// File: rtl/fir_error_monitor.sv
// Streaming accuracy monitor for the approximate FIR. Compares each valid
// approx/exact pair over a window of WINDOW pairs and accumulates mismatch
// count, maximum and (saturating) sum of absolute errors, then holds them.
// Two-stage pipeline: stage 1 registers the difference, stage 2 commits it.
// Optional feature macro: FIR_ERR_SQ_EN adds a squared-error accumulator
// (sum_sq_err port) fed by a squaring stage in pipeline stage 1.
module fir_error_monitor
   import fir_pkg::*;
#(
   parameter int WINDOW = 256,
   parameter int SUM_W  = 32
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] approx,
   input  logic [SAMPLE_W-1:0] exact,
   output logic                busy,
   output logic                done,
   output logic [SAMPLE_W-1:0] err_count,
   output logic [SAMPLE_W-1:0] max_err,
   output logic [SUM_W-1:0]    sum_err
`ifdef FIR_ERR_SQ_EN
   ,
   output logic [SQ_ACC_W-1:0] sum_sq_err
`endif
);

   localparam logic [15:0] LAST_IDX = 16'(WINDOW - 1);

   fir_err_state_t state_q, state_d;
   logic [15:0]    cnt_q, cnt_d;

   logic                accept;
   logic                clear;
   logic [SAMPLE_W-1:0] diff_c;
   logic                nz_c;

   logic                s1_valid_q;
   logic [SAMPLE_W-1:0] diff_q;
   logic                nz_q;

   logic                busy_q;
   logic                done_q;
   logic [SAMPLE_W-1:0] err_count_q;
   logic [SAMPLE_W-1:0] max_err_q;
   logic [SUM_W-1:0]    sum_err_q;

   // A pair is only taken while the window is open; start only from rest.
   assign accept = (state_q == RUN) && in_valid;
   assign clear  = start && ((state_q == IDLE) || (state_q == DONE));

   // Next-state and sample-counter logic for the measurement sequence.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (in_valid) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == LAST_IDX) state_d = DRAIN;
            end
         end
         // The final pair sits in stage 1 here and commits on this edge.
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers; reset returns to IDLE.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   abs_diff16 u_abs_diff (
      .a       (approx),
      .b       (exact),
      .mag     (diff_c),
      .nonzero (nz_c)
   );

   // Stage 1 valid flag; reset flushes any pair in flight.
   always_ff @(posedge clk) begin
      if (rst) s1_valid_q <= 1'b0;
      else     s1_valid_q <= accept;
   end

   // Stage 1 data registers.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath registers carry no reset; they are only consumed when s1_valid_q qualifies them.
      diff_q <= diff_c;
      nz_q   <= nz_c;
   end

`ifdef FIR_ERR_SQ_EN
   logic [31:0]          sq_q;
   logic [SQ_ACC_W-1:0]  sum_sq_q;

   // Stage 1 squaring register.
   always_ff @(posedge clk) begin
      sq_q <= 32'(diff_c) * 32'(diff_c);
   end

   // Stage 2 squared-error accumulator, saturating at 40 bits.
   always_ff @(posedge clk) begin
      if (rst || clear)    sum_sq_q <= '0;
      else if (s1_valid_q) sum_sq_q <= SQ_ACC_W'(sat_add(64'(sum_sq_q), 64'(sq_q), SQ_ACC_W));
   end

   assign sum_sq_err = sum_sq_q;
`else
   // Squared-error path is not built in this configuration.
`endif

   // Stage 2 commit of error statistics plus registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_count_q <= '0;
         max_err_q   <= '0;
         sum_err_q   <= '0;
      end else begin
         busy_q <= (state_d == RUN) || (state_d == DRAIN);
         done_q <= (state_d == DONE);
         if (clear) begin
            err_count_q <= '0;
            max_err_q   <= '0;
            sum_err_q   <= '0;
         end else if (s1_valid_q) begin
            err_count_q <= err_count_q + {{(SAMPLE_W-1){1'b0}}, nz_q};
            max_err_q   <= (diff_q > max_err_q) ? diff_q : max_err_q;
            sum_err_q   <= SUM_W'(sat_add(64'(sum_err_q), 64'(diff_q), SUM_W));
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err_count = err_count_q;
   assign max_err   = max_err_q;
   assign sum_err   = sum_err_q;

endmodule

// File: tb/tb_fir_error_monitor.sv
// Bench for fir_error_monitor: two instances (32-bit and 17-bit sum) share
// one stimulus stream; a transaction-level model predicts every output and
// is compared each cycle, with literal expectations for directed scenarios.
module tb_fir_error_monitor;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [15:0] approx;
   logic [15:0] exact;

   logic        busy_a, done_a, busy_b, done_b;
   logic [15:0] errc_a, maxe_a, errc_b, maxe_b;
   logic [31:0] sum_a;
   logic [16:0] sum_b;
`ifdef FIR_ERR_SQ_EN
   logic [39:0] sq_a, sq_b;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   fir_error_monitor #(.WINDOW(W), .SUM_W(32)) dut_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .approx(approx), .exact(exact), .busy(busy_a), .done(done_a),
      .err_count(errc_a), .max_err(maxe_a), .sum_err(sum_a)
`ifdef FIR_ERR_SQ_EN
      , .sum_sq_err(sq_a)
`endif
   );

   fir_error_monitor #(.WINDOW(W), .SUM_W(17)) dut_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .approx(approx), .exact(exact), .busy(busy_b), .done(done_b),
      .err_count(errc_b), .max_err(maxe_b), .sum_err(sum_b)
`ifdef FIR_ERR_SQ_EN
      , .sum_sq_err(sq_b)
`endif
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint clamp_add(input longint acc, input longint inc, input int w);
      longint lim;
      lim = (longint'(1) << w) - 1;
      return (acc + inc > lim) ? lim : acc + inc;
   endfunction

   // Model: a measurement is open from an accepted start until its W-th pair
   // has been folded in; each pair is folded one edge after it is taken.
   bit     m_busy, m_done;
   int     m_taken;
   longint m_cnt, m_max, m_sum32, m_sum17, m_sq;
   bit     pend, pend_last;
   longint pend_diff;

   always @(posedge clk) begin : model
      bit     was_busy, take;
      longint d;
      if (rst) begin
         m_busy = 0; m_done = 0; m_taken = 0; pend = 0; pend_last = 0;
         m_cnt = 0; m_max = 0; m_sum32 = 0; m_sum17 = 0; m_sq = 0;
      end else begin
         was_busy = m_busy;
         take     = was_busy && (m_taken < W) && in_valid;
         d        = (approx >= exact) ? longint'(approx) - longint'(exact)
                                      : longint'(exact) - longint'(approx);
         if (pend) begin
            if (pend_diff != 0) m_cnt++;
            if (pend_diff > m_max) m_max = pend_diff;
            m_sum32 = clamp_add(m_sum32, pend_diff, 32);
            m_sum17 = clamp_add(m_sum17, pend_diff, 17);
            m_sq    = clamp_add(m_sq, pend_diff * pend_diff, 40);
            if (pend_last) begin
               m_busy = 0;
               m_done = 1;
            end
         end
         pend      = take;
         pend_diff = d;
         pend_last = take && (m_taken + 1 == W);
         if (take) m_taken++;
         if (!was_busy && start) begin
            m_busy = 1; m_done = 0; m_taken = 0;
            m_cnt = 0; m_max = 0; m_sum32 = 0; m_sum17 = 0; m_sq = 0;
         end
      end
   end

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy_a", busy_a, m_busy);
         check("done_a", done_a, m_done);
         check("err_count_a", errc_a, m_cnt);
         check("max_err_a", maxe_a, m_max);
         check("sum_err_a", sum_a, m_sum32);
         check("busy_b", busy_b, m_busy);
         check("done_b", done_b, m_done);
         check("err_count_b", errc_b, m_cnt);
         check("max_err_b", maxe_b, m_max);
         check("sum_err_b", sum_b, m_sum17);
`ifdef FIR_ERR_SQ_EN
         check("sum_sq_err_a", sq_a, m_sq);
         check("sum_sq_err_b", sq_b, m_sq);
`endif
      end
   end

   task automatic step(input bit r, input bit s, input bit v,
                       input logic [15:0] a, input logic [15:0] e);
      @(negedge clk);
      rst = r; start = s; in_valid = v; approx = a; exact = e;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic check_lit(input string tag, input bit dn, input bit bs,
                            input longint ec, input longint me, input longint s32,
                            input longint s17);
      check({tag, "_done"}, done_a, dn);
      check({tag, "_busy"}, busy_a, bs);
      check({tag, "_err_count"}, errc_a, ec);
      check({tag, "_max_err"}, maxe_a, me);
      check({tag, "_sum_err32"}, sum_a, s32);
      check({tag, "_sum_err17"}, sum_b, s17);
   endtask

   initial begin
      logic [15:0] a, e;
      bit          vseq [7];
      rst = 1; start = 0; in_valid = 0; approx = 0; exact = 0;
      @(negedge clk);
      cmp_en = 1'b1;
      check_lit("reset", 0, 0, 0, 0, 0, 0);
      idle();

      // Identical samples: no error, done two edges after the 4th pair.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h1234, 16'h1234);
      idle();
      check("equal_done_edge1", done_a, 0);
      idle();
      check_lit("equal", 1, 0, 0, 0, 0, 0);

      // Mixed differences 3,1,0,16; start during the DRAIN cycle is ignored.
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 16'h0010, 16'h0013);
      step(0, 0, 1, 16'h0020, 16'h001F);
      step(0, 0, 1, 16'h0005, 16'h0005);
      step(0, 0, 1, 16'h8000, 16'h7FF0);
      step(0, 1, 0, 0, 0);
      idle();
      check_lit("mixed", 1, 0, 3, 16'h0010, 20, 20);
`ifdef FIR_ERR_SQ_EN
      check("mixed_sum_sq", sq_a, 266);
`endif

      // Gapped valid stream with diff 2 and a start pulse mid-run.
      vseq = '{1, 0, 0, 1, 0, 1, 1};
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         a = 16'(16'h0100 + 16'(i * 7));
         e = a - 16'd2;
         step(0, (i == 2), vseq[i], a, e);
      end
      idle();
      idle();
      check_lit("gapped", 1, 0, 4, 2, 8, 8);

      // Largest difference: 17-bit sum saturates, 32-bit does not.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 16'hFFFF, 16'h0000);
      idle();
      idle();
      check_lit("maxdiff", 1, 0, 4, 16'hFFFF, 32'h0003_FFFC, 17'h1_FFFF);

      // Reset mid-measurement (with a coincident start) then a fresh run.
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 16'd50, 16'd10);
      step(0, 0, 1, 16'd10, 16'd90);
      step(1, 1, 1, 16'd0, 16'd100);
      idle();
      check_lit("rst_mid", 0, 0, 0, 0, 0, 0);
      idle();
      check("rst_start_discarded", busy_a, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(16'd1000 + 16'(i)), 16'd1000);
      idle();
      idle();
      check_lit("fresh", 1, 0, 4, 4, 10, 10);

      // Pairs after done are ignored; a new start clears the results.
      for (int i = 0; i < 3; i++) step(0, 0, 1, 16'hF000, 16'h0001);
      idle();
      check_lit("frozen", 1, 0, 4, 4, 10, 10);
      step(0, 1, 0, 0, 0);
      idle();
      check_lit("restart", 0, 1, 0, 0, 0, 0);

      // Randomized traffic, occasional starts and resets.
      for (int i = 0; i < 800; i++) begin
         bit r, s, v;
         int mode;
         r    = ($urandom_range(0, 199) == 0);
         s    = ($urandom_range(0, 5) == 0);
         v    = ($urandom_range(0, 3) != 0);
         mode = $urandom_range(0, 3);
         a    = 16'($urandom);
         case (mode)
            0:       e = a;
            1:       e = a ^ 16'($urandom_range(0, 7));
            2:       e = 16'($urandom);
            default: begin a = 16'hFFFF; e = 16'h0000; end
         endcase
         step(r, s, v, a, e);
      end
      idle();
      idle();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fir_error_monitor.md
# fir_error_monitor

Streaming quality monitor for the approximate FIR datapath. It sits at the output end of the approximate filter and consumes its 16-bit `dataout` stream alongside the matching sample from an exact-arithmetic reference filter. Over a programmable window of valid samples it accumulates error statistics: mismatch count, maximum absolute error and sum of absolute errors. It then holds the results for readout, so the accuracy cost of each approximate adder configuration can be measured in hardware.

## Interface
Parameters:
- `WINDOW`, 256: number of valid sample pairs per measurement; legal range 1..65535.
- `SUM_W`, 32: width of the absolute-error accumulator.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: single-cycle pulse that begins a measurement.
- `in_valid`, in, 1: `approx` and `exact` carry a sample pair this cycle.
- `approx`, in, 16: unsigned output sample from the approximate FIR.
- `exact`, in, 16: unsigned output sample from the exact reference FIR.
- `busy`, out, 1: measurement in progress.
- `done`, out, 1: results final; held high until the next accepted `start` or `rst`.
- `err_count`, out, 16: number of pairs with `approx != exact`.
- `max_err`, out, 16: largest |approx − exact| seen.
- `sum_err`, out, `SUM_W`: sum of |approx − exact|, saturating.
- `sum_sq_err`, out, 40: sum of squared errors, saturating. Present only with `FIR_ERR_SQ_EN`.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1: clear all result registers and the sample counter, then go to RUN. `done` drops and `busy` rises on the next edge.
- RUN:
  - Each cycle with `in_valid`=1 accepts one pair and increments the counter.
  - When the WINDOW-th pair is accepted, go to DRAIN.
  - `in_valid`=0 cycles are simply skipped; no timeout applies.
- DRAIN: wait until the pipeline has committed the last pair, then go to DONE.
- DONE: results are frozen, `done`=1 and `busy`=0. Further `in_valid` is ignored.
- `start` in RUN or DRAIN is ignored. `in_valid` in IDLE, DRAIN or DONE is ignored.
- Arithmetic:
  - The absolute difference is computed unsigned: `approx >= exact ? approx - exact : exact - approx`. Width is 16 bits and it cannot overflow.
  - `err_count` increments when the difference is nonzero. It cannot exceed `WINDOW`, so it needs no saturation.
  - `max_err` takes the larger of the current value and the difference.
  - `sum_err` adds the difference, clamped at all-ones.

## Timing
- All outputs are registered. Reset values: `busy`=0, `done`=0, `err_count`=0, `max_err`=0, `sum_err`=0, `sum_sq_err`=0.
- The pipeline has 2 stages:
  - Edge 1 after acceptance: difference register (and square register, if enabled).
  - Edge 2 after acceptance: accumulators updated.
- `done` rises on the same edge that commits the final pair, which is 2 edges after the WINDOW-th pair is accepted. DRAIN lasts exactly 1 cycle.
- Accumulators change only on commit edges, with at most one update per cycle.
- `rst` mid-measurement: on the next edge, all state and results clear, the pipeline is flushed and the FSM is in IDLE.
- A `start` coincident with `rst` is discarded.
- A `start` arriving in the same cycle that DONE is entered (the DRAIN cycle) is ignored.

## Configuration
- `FIR_ERR_SQ_EN`: when defined, adds a squaring stage (16×16 → 32) in pipeline stage 1, plus the `sum_sq_err` port and its 40-bit saturating accumulator. Latency is unchanged.
- When undefined, the port, multiplier and accumulator are absent.

## Structure
- Shared package `fir_pkg`:
  - sample width constant (16)
  - `SQ_ACC_W` (40)
  - FSM state enum `fir_err_state_t`
  - saturating-add helper function
- Sub-module `abs_diff16` (combinational): takes 16-bit `a` and `b` and produces the 16-bit magnitude plus a nonzero flag. It is instantiated once in stage 1.

## Test plan
- `WINDOW`=4, four pairs with `approx`=`exact`=0x1234 → `err_count`=0, `max_err`=0, `sum_err`=0. `done`=1 exactly 2 edges after the 4th pair.
- `WINDOW`=4, pairs (0x0010,0x0013), (0x0020,0x001F), (0x0005,0x0005), (0x8000,0x7FF0) → `err_count`=3, `max_err`=0x0010, `sum_err`=20. With `FIR_ERR_SQ_EN`: `sum_sq_err`=266.
- `WINDOW`=4 with `in_valid` toggling 1,0,0,1,0,1,1 and diff 2 each → completes after the 4th valid only, `sum_err`=8. `start` pulsed during RUN has no effect.
- `SUM_W`=17, `WINDOW`=4, diff 0xFFFF each → `sum_err`=0x1FFFF (saturated), `max_err`=0xFFFF, `err_count`=4.
- `rst` asserted after 2 of 4 pairs → all outputs 0 and `busy`=0 next edge. A following `start` plus 4 pairs gives a fresh correct result.
- After `done`, extra `in_valid` pairs leave results unchanged. A new `start` clears `done` and all results on the next edge.
